// File: rtl/chn_ep_arb_pkg.sv
// Shared definitions for the TRN tx endpoint arbiter: FSM encoding,
// error flag bit positions and a counter sizing helper.
package chn_ep_arb_pkg;

   typedef enum logic [1:0] {
      ST_GAP   = 2'd0,
      ST_OFFER = 2'd1,
      ST_DRIVE = 2'd2
   } arb_st_e;

   localparam int ARB_ERR_VIOL = 0;
   localparam int ARB_ERR_TMO  = 1;

   // Width of a counter that must be able to hold max_val itself.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/chn_ep_arb_if.sv
// Channel-facing handshake bundle of the TRN tx endpoint arbiter.
// The master modport is the arbiter side, the slave modport the channel side.
interface chn_ep_arb_if #(
   parameter int NUM_CHN = 2
) ();
   localparam int CW = $clog2(NUM_CHN);

   logic [NUM_CHN-1:0] chn_trn;
   logic [NUM_CHN-1:0] chn_drvn;
   logic [NUM_CHN-1:0] chn_reqep;
   logic               err_clr;
   logic               ep_busy;
   logic [CW-1:0]      cur_chn;
   logic [1:0]         arb_err;

   modport master (
      output chn_trn, ep_busy, cur_chn, arb_err,
      input  chn_drvn, chn_reqep, err_clr
   );

   modport slave (
      input  chn_trn, ep_busy, cur_chn, arb_err,
      output chn_drvn, chn_reqep, err_clr
   );
endinterface

// File: rtl/chn_ep_arb_rr_pick.sv
// Rotate-and-priority-encode: first set bit of req_i strictly after cur_i,
// wrapping at NUM_CHN-1; cur_i itself is the last candidate.
module chn_rr_pick
   import chn_ep_arb_pkg::*;
#(
   parameter int  NUM_CHN = 2,
   localparam int CW      = $clog2(NUM_CHN)
) (
   input  logic [NUM_CHN-1:0] req_i,
   input  logic [CW-1:0]      cur_i,
   output logic [CW-1:0]      nxt_o
);

   logic          found;
   logic [CW-1:0] idx;

   // Scan candidates in round-robin order, keeping the first hit.
   always_comb begin
      nxt_o = cur_i;
      found = 1'b0;
      idx   = cur_i;
      for (int k = 1; k <= NUM_CHN; k++) begin
         idx = CW'((int'(cur_i) + k) % NUM_CHN);
         if (!found && req_i[idx]) begin
            nxt_o = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/chn_ep_arb.sv
// TRN tx endpoint arbiter: offers the endpoint round-robin (requesters first),
// withdraws unused offers after TURN_CYC cycles, flags violations and stuck drivers.
module chn_ep_arb
   import chn_ep_arb_pkg::*;
#(
   parameter int NUM_CHN  = 2,
   parameter int TURN_CYC = 4,
   parameter int MAX_DRV  = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   chn_ep_arb_if.master bus
);

   localparam int CW = $clog2(NUM_CHN);
   localparam int OW = cnt_w(TURN_CYC);
   localparam int DW = cnt_w(MAX_DRV);

   localparam logic [CW-1:0]      LAST_CHN = CW'(NUM_CHN - 1);
   localparam logic [OW-1:0]      OFF_LAST = OW'(TURN_CYC - 1);
   localparam logic [DW-1:0]      DRV_MAX  = DW'(MAX_DRV);
   localparam logic [DW-1:0]      DRV_PRE  = DW'(MAX_DRV - 1);
   localparam logic [NUM_CHN-1:0] ONE_OH   = NUM_CHN'(1);

   arb_st_e            state_q,   state_d;
   logic [NUM_CHN-1:0] chn_trn_q, chn_trn_d;
   logic               ep_busy_q, ep_busy_d;
   logic [CW-1:0]      cur_chn_q, cur_chn_d;
   logic [1:0]         arb_err_q, arb_err_d;
   logic [OW-1:0]      off_cnt_q, off_cnt_d;
   logic [DW-1:0]      drv_cnt_q, drv_cnt_d;

   logic [NUM_CHN-1:0] cur_oh;
   logic [NUM_CHN-1:0] nxt_oh;
   logic [NUM_CHN-1:0] pick_mask;
   logic [CW-1:0]      pick_idx;
   logic               cur_drvn;
   logic               viol;
   logic               tmo;

   assign cur_oh    = ONE_OH << cur_chn_q;
   assign cur_drvn  = |(bus.chn_drvn & cur_oh);
   // With no requester every channel is a candidate, giving plain rotation.
   assign pick_mask = (|bus.chn_reqep) ? bus.chn_reqep : {NUM_CHN{1'b1}};

   chn_rr_pick #(
      .NUM_CHN (NUM_CHN)
   ) u_pick (
      .req_i (pick_mask),
      .cur_i (cur_chn_q),
      .nxt_o (pick_idx)
   );

   // Next state, counters and next registered outputs.
   always_comb begin
      state_d   = state_q;
      cur_chn_d = cur_chn_q;
      off_cnt_d = off_cnt_q;
      drv_cnt_d = drv_cnt_q;
      viol      = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         ST_GAP: begin
            viol      = |bus.chn_drvn;
            cur_chn_d = pick_idx;
            off_cnt_d = '0;
            drv_cnt_d = '0;
            state_d   = ST_OFFER;
         end
         ST_OFFER: begin
            viol      = |(bus.chn_drvn & ~cur_oh);
            off_cnt_d = off_cnt_q + OW'(1);
            if (cur_drvn) begin
               state_d = ST_DRIVE;
            end else if (off_cnt_q == OFF_LAST) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_OFFER;
            end
         end
         ST_DRIVE: begin
            viol = |(bus.chn_drvn & ~cur_oh);
            tmo  = (drv_cnt_q == DRV_PRE);
            if (drv_cnt_q != DRV_MAX) begin
               drv_cnt_d = drv_cnt_q + DW'(1);
            end else begin
               drv_cnt_d = drv_cnt_q;
            end
            // No preemption: only the owner releasing drvn ends the turn.
            if (cur_drvn) begin
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d   = ST_GAP;
            cur_chn_d = LAST_CHN;
            off_cnt_d = '0;
            drv_cnt_d = '0;
         end
      endcase

      nxt_oh    = ONE_OH << cur_chn_d;
      chn_trn_d = (state_d == ST_GAP) ? {NUM_CHN{1'b0}} : nxt_oh;
      ep_busy_d = (state_d == ST_DRIVE);
      arb_err_d = arb_err_q & ~{2{bus.err_clr}};
      arb_err_d[ARB_ERR_VIOL] = arb_err_d[ARB_ERR_VIOL] | viol;
      arb_err_d[ARB_ERR_TMO]  = arb_err_d[ARB_ERR_TMO]  | tmo;
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_GAP;
         chn_trn_q <= '0;
         ep_busy_q <= 1'b0;
         cur_chn_q <= LAST_CHN;
         arb_err_q <= 2'b00;
         off_cnt_q <= '0;
         drv_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         chn_trn_q <= chn_trn_d;
         ep_busy_q <= ep_busy_d;
         cur_chn_q <= cur_chn_d;
         arb_err_q <= arb_err_d;
         off_cnt_q <= off_cnt_d;
         drv_cnt_q <= drv_cnt_d;
      end
   end

   assign bus.chn_trn = chn_trn_q;
   assign bus.ep_busy = ep_busy_q;
   assign bus.cur_chn = cur_chn_q;
   assign bus.arb_err = arb_err_q;

endmodule

// File: tb/tb_chn_ep_arb.sv
// Bench for chn_ep_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_chn_ep_arb;

   localparam int NCH = 4;
   localparam int TC  = 4;
   localparam int MD  = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] drvn;
   logic [NCH-1:0] reqep;
   logic           clr;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   chn_ep_arb_if #(.NUM_CHN(NCH)) bus ();

   assign bus.chn_drvn  = drvn;
   assign bus.chn_reqep = reqep;
   assign bus.err_clr   = clr;

   chn_ep_arb #(
      .NUM_CHN  (NCH),
      .TURN_CYC (TC),
      .MAX_DRV  (MD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural view: who holds the grant, whether it is being used,
   // how long the offer / drive has lasted, and the sticky error flags.
   int       m_cur = NCH - 1;
   bit       m_gr  = 1'b0;
   bit       m_bz  = 1'b0;
   int       m_age = 0;
   int       m_drv = 0;
   logic [1:0] m_err = 2'b00;

   function automatic int next_rr(input int cur, input logic [NCH-1:0] req);
      if (req == '0) return (cur + 1) % NCH;
      for (int k = 1; k <= NCH; k++) begin
         if (req[(cur + k) % NCH]) return (cur + k) % NCH;
      end
      return cur;
   endfunction

   function automatic logic [NCH-1:0] m_trn();
      logic [NCH-1:0] v;
      v = '0;
      if (m_gr) v[m_cur] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      int         cur, age, drv;
      bit         gr, bz;
      logic [1:0] ev;
      logic [NCH-1:0] own;
      if (!rst_n) begin
         m_cur <= NCH - 1;
         m_gr  <= 1'b0;
         m_bz  <= 1'b0;
         m_age <= 0;
         m_drv <= 0;
         m_err <= 2'b00;
      end else begin
         cur = m_cur; gr = m_gr; bz = m_bz; age = m_age; drv = m_drv;
         ev  = 2'b00;
         own = '0;
         own[cur] = 1'b1;
         if (!gr) begin
            ev[0] = (drvn != '0);
            cur = next_rr(cur, reqep);
            gr = 1'b1; bz = 1'b0; age = 0; drv = 0;
         end else if (!bz) begin
            ev[0] = ((drvn & ~own) != '0);
            if (drvn[cur]) begin
               bz = 1'b1;
            end else begin
               age++;
               if (age == TC) gr = 1'b0;
            end
         end else begin
            ev[0] = ((drvn & ~own) != '0);
            drv++;
            if (drv == MD) ev[1] = 1'b1;
            if (!drvn[cur]) begin
               gr = 1'b0; bz = 1'b0;
            end
         end
         m_cur <= cur; m_gr <= gr; m_bz <= bz; m_age <= age; m_drv <= drv;
         m_err <= (m_err & ~{2{clr}}) | ev;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("chn_trn", 32'(bus.chn_trn), 32'(m_trn()));
         check("ep_busy", 32'(bus.ep_busy), 32'(m_bz));
         check("cur_chn", 32'(bus.cur_chn), 32'(m_cur));
         check("arb_err", 32'(bus.arb_err), 32'(m_err));
         check("trn_onehot", 32'($countones(bus.chn_trn) <= 1), 32'(1));
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      drvn  = '0;
      reqep = '0;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_trn", 32'(bus.chn_trn), 32'h0);
      check("rst_busy", 32'(bus.ep_busy), 32'h0);
      check("rst_cur", 32'(bus.cur_chn), 32'h3);
      check("rst_err", 32'(bus.arb_err), 32'h0);
      rst_n = 1'b1;
   endtask

   logic [3:0] rot_exp [14] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                4'h4, 4'h4, 4'h4, 4'h4};

   initial begin
      int busy_cnt;
      int hold;
      int r;
      rst_n = 1'b1;
      drvn  = '0;
      reqep = '0;
      clr   = 1'b0;
      #2 rst_n = 1'b0;
      cmp_en = 1'b1;

      // Plain rotation with no drivers.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         check("rot_trn", 32'(bus.chn_trn), 32'(rot_exp[i]));
         if (i == 0) check("rot_cur0", 32'(bus.cur_chn), 32'h0);
         if (i == 5) check("rot_cur1", 32'(bus.cur_chn), 32'h1);
      end

      // Channel 0 drives from its 2nd offer cycle for 10 cycles.
      do_reset();
      repeat (2) @(negedge clk);
      drvn = 4'b0001;
      busy_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ep_busy) busy_cnt++;
      end
      drvn = 4'b0000;
      check("busy_len", 32'(busy_cnt), 32'd10);
      @(negedge clk);
      check("hand_t1_trn", 32'(bus.chn_trn), 32'h0);
      check("hand_t1_busy", 32'(bus.ep_busy), 32'h0);
      @(negedge clk);
      check("hand_t2_trn", 32'(bus.chn_trn), 32'h2);

      // Requesters 0 and 3 win over channel 2.
      do_reset();
      repeat (10) @(negedge clk);
      check("req_gap_cur", 32'(bus.cur_chn), 32'h1);
      check("req_gap_trn", 32'(bus.chn_trn), 32'h0);
      reqep = 4'b1001;
      @(negedge clk);
      check("req_first", 32'(bus.cur_chn), 32'h3);
      check("req_first_trn", 32'(bus.chn_trn), 32'h8);
      repeat (5) @(negedge clk);
      check("req_second", 32'(bus.cur_chn), 32'h0);
      repeat (5) @(negedge clk);
      check("req_third", 32'(bus.cur_chn), 32'h3);
      reqep = 4'b0000;

      // Non-granted channel drives; then clear the flag.
      do_reset();
      @(negedge clk);
      drvn = 4'b0010;
      @(negedge clk);
      drvn = 4'b0000;
      check("viol_err", 32'(bus.arb_err), 32'h1);
      check("viol_trn", 32'(bus.chn_trn), 32'h1);
      @(negedge clk);
      check("viol_sticky", 32'(bus.arb_err), 32'h1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("viol_clr", 32'(bus.arb_err), 32'h0);

      // Drive timeout after MD drive cycles, no preemption.
      do_reset();
      @(negedge clk);
      drvn = 4'b0001;
      repeat (16) @(negedge clk);
      check("tmo_before", 32'(bus.arb_err), 32'h0);
      @(negedge clk);
      check("tmo_set", 32'(bus.arb_err), 32'h2);
      repeat (3) @(negedge clk);
      check("tmo_hold_trn", 32'(bus.chn_trn), 32'h1);
      check("tmo_hold_busy", 32'(bus.ep_busy), 32'h1);
      drvn = 4'b0000;
      @(negedge clk);
      check("tmo_rel_trn", 32'(bus.chn_trn), 32'h0);
      @(negedge clk);
      check("tmo_next_trn", 32'(bus.chn_trn), 32'h2);
      check("tmo_sticky", 32'(bus.arb_err), 32'h2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("tmo_clr", 32'(bus.arb_err), 32'h0);

      // Asynchronous reset in the middle of a drive.
      do_reset();
      @(negedge clk);
      drvn = 4'b0001;
      repeat (4) @(negedge clk);
      check("ar_pre_busy", 32'(bus.ep_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_trn", 32'(bus.chn_trn), 32'h0);
      check("ar_busy", 32'(bus.ep_busy), 32'h0);
      do_reset();
      @(negedge clk);
      check("ar_restart_cur", 32'(bus.cur_chn), 32'h0);
      check("ar_restart_trn", 32'(bus.chn_trn), 32'h1);

      // Randomized traffic: mostly well-behaved owners, occasional rogue drvn.
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reqep = ($urandom_range(0, 2) == 0) ? NCH'($urandom_range(0, 15)) : '0;
         clr   = ($urandom_range(0, 19) == 0);
         if (hold > 0) hold--;
         else drvn = '0;
         if (drvn == '0 && bus.chn_trn != '0 && !bus.ep_busy && $urandom_range(0, 2) == 0) begin
            drvn = bus.chn_trn;
            hold = $urandom_range(0, 22);
         end
         if ($urandom_range(0, 59) == 0) begin
            r = $urandom_range(0, NCH - 1);
            drvn[r] = ~drvn[r];
         end
      end
      drvn  = '0;
      reqep = '0;
      clr   = 1'b0;
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
